// File: rtl/data_island_packet_receiver_if.sv
// Character-in / packet-out bundle between an HDMI TMDS lane aligner and the data island receiver.
// master drives the three word-aligned TMDS characters and slave returns the decoded packets.
interface data_island_packet_receiver_if;
  logic [9:0]  channel0;
  logic [9:0]  channel1;
  logic [9:0]  channel2;
  logic        dataIslandActive;
  logic        packetValid;
  logic [23:0] header;
  logic [55:0] subpacket0;
  logic [55:0] subpacket1;
  logic [55:0] subpacket2;
  logic [55:0] subpacket3;
  logic        headerEccOk;
  logic [3:0]  subpacketEccOk;
  logic        hSyncOut;
  logic        vSyncOut;
  logic        islandError;

  modport master (
    output channel0, channel1, channel2,
    input  dataIslandActive, packetValid, header, subpacket0, subpacket1, subpacket2,
           subpacket3, headerEccOk, subpacketEccOk, hSyncOut, vSyncOut, islandError
  );

  modport slave (
    input  channel0, channel1, channel2,
    output dataIslandActive, packetValid, header, subpacket0, subpacket1, subpacket2,
           subpacket3, headerEccOk, subpacketEccOk, hSyncOut, vSyncOut, islandError
  );
endinterface

// File: rtl/data_island_packet_receiver.sv
// HDMI sink data island receiver: tracks preamble/guard bands, TERC4-decodes each
// 32-character packet into header plus four subpackets and checks their BCH parity bytes.
module data_island_packet_receiver #(
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter int unsigned MAX_PACKETS  = 18
) (
  input logic                          pixelClock,
  input logic                          resetN,
  data_island_packet_receiver_if.slave rx
);
  localparam int unsigned NSUB      = 4;
  localparam int unsigned HDR_BITS  = 32;
  localparam int unsigned SUB_BITS  = 64;
  localparam logic [9:0]  PRE_CODE  = 10'b0010101011;
  localparam logic [9:0]  GB_CODE   = 10'b0100110011;
  localparam logic [7:0]  BCH_POLY  = 8'h83;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGB, S_PKT, S_TGB} state_e;

  // Returns {valid, nibble}; anything outside the 16 TERC4 codes is invalid.
  function automatic logic [4:0] terc4_dec(input logic [9:0] c);
    case (c)
      10'b1010011100: terc4_dec = 5'h10;
      10'b1001100011: terc4_dec = 5'h11;
      10'b1011100100: terc4_dec = 5'h12;
      10'b1011100010: terc4_dec = 5'h13;
      10'b0101110001: terc4_dec = 5'h14;
      10'b0100011110: terc4_dec = 5'h15;
      10'b0110001110: terc4_dec = 5'h16;
      10'b0100111100: terc4_dec = 5'h17;
      10'b1011001100: terc4_dec = 5'h18;
      10'b0100111001: terc4_dec = 5'h19;
      10'b0110011100: terc4_dec = 5'h1A;
      10'b1011000110: terc4_dec = 5'h1B;
      10'b1010001110: terc4_dec = 5'h1C;
      10'b1001110001: terc4_dec = 5'h1D;
      10'b0101100011: terc4_dec = 5'h1E;
      10'b1011000011: terc4_dec = 5'h1F;
      default:        terc4_dec = 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
    bch_step = (e >> 1) ^ ((e[0] ^ b) ? BCH_POLY : 8'h00);
  endfunction

  state_e                        state_q, state_d;
  logic [3:0]                    pre_cnt_q, pre_cnt_d;
  logic [4:0]                    idx_q, idx_d;
  logic [4:0]                    pkt_cnt_q, pkt_cnt_d;
  logic                          more_q, more_d;
  logic [HDR_BITS-1:0]           hdr_sr_q, hdr_sr_d;
  logic [7:0]                    hdr_ecc_q, hdr_ecc_d;
  logic [NSUB-1:0][SUB_BITS-1:0] sp_sr_q, sp_sr_d;
  logic [NSUB-1:0][7:0]          sp_ecc_q, sp_ecc_d;
  logic [23:0]                   header_q, header_d;
  logic [NSUB-1:0][55:0]         sub_q, sub_d;
  logic                          hdr_ok_q, hdr_ok_d;
  logic [NSUB-1:0]               sp_ok_q, sp_ok_d;
  logic                          active_q, active_d;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic                          hsync_q, hsync_d;
  logic                          vsync_q, vsync_d;

  logic [4:0] t0_c, t1_c, t2_c;
  logic       is_pre_c, is_gb_c, data_ok_c, first_c, take_c;

  assign t0_c      = terc4_dec(rx.channel0);
  assign t1_c      = terc4_dec(rx.channel1);
  assign t2_c      = terc4_dec(rx.channel2);
  assign is_pre_c  = (rx.channel1 == PRE_CODE) && (rx.channel2 == PRE_CODE);
  assign is_gb_c   = (rx.channel1 == GB_CODE) && (rx.channel2 == GB_CODE) &&
                     t0_c[4] && t0_c[3] && t0_c[2];
  // ch0 bit 3 flags "not the first character of a packet".
  assign data_ok_c = t0_c[4] && t1_c[4] && t2_c[4] && (t0_c[3] == (idx_q != 5'd0));
  assign first_c   = (idx_q == 5'd0);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    idx_d     = idx_q;
    pkt_cnt_d = pkt_cnt_q;
    more_d    = more_q;
    hdr_sr_d  = hdr_sr_q;
    hdr_ecc_d = hdr_ecc_q;
    sp_sr_d   = sp_sr_q;
    sp_ecc_d  = sp_ecc_q;
    header_d  = header_q;
    sub_d     = sub_q;
    hdr_ok_d  = hdr_ok_q;
    sp_ok_d   = sp_ok_q;
    active_d  = 1'b0;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    take_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_pre_c) begin
          state_d   = S_PRE;
          pre_cnt_d = 4'd1;
        end
      end
      S_PRE: begin
        if (is_pre_c) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (is_gb_c && (32'(pre_cnt_q) >= MIN_PREAMBLE)) begin
          state_d  = S_LGB;
          active_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LGB: begin
        if (is_gb_c) begin
          state_d   = S_PKT;
          idx_d     = 5'd0;
          pkt_cnt_d = 5'd0;
          more_d    = 1'b0;
          active_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_PKT: begin
        // more_q marks the character right after a completed packet.
        if (more_q && is_gb_c) begin
          state_d  = S_TGB;
          more_d   = 1'b0;
          active_d = 1'b1;
        end else if (!data_ok_c || (more_q && (32'(pkt_cnt_q) >= MAX_PACKETS))) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          take_c   = 1'b1;
          active_d = 1'b1;
        end
      end
      S_TGB: begin
        state_d = S_IDLE;
        if (is_gb_c) active_d = 1'b1;
        else         err_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    hsync_d = active_d ? t0_c[0] : hsync_q;
    vsync_d = active_d ? t0_c[1] : vsync_q;

    // Deserialize one packet character; ECC runs over data bits only.
    if (take_c) begin
      hdr_sr_d = {t0_c[2], hdr_sr_q[HDR_BITS-1:1]};
      if (idx_q < 5'd24) hdr_ecc_d = bch_step(first_c ? 8'h00 : hdr_ecc_q, t0_c[2]);
      idx_d  = idx_q + 5'd1;
      more_d = (idx_q == 5'd31);
      for (int k = 0; k < NSUB; k++) begin
        sp_sr_d[k] = {t2_c[k], t1_c[k], sp_sr_q[k][SUB_BITS-1:2]};
        if (idx_q < 5'd28)
          sp_ecc_d[k] = bch_step(bch_step(first_c ? 8'h00 : sp_ecc_q[k], t1_c[k]), t2_c[k]);
        if (idx_q == 5'd31) begin
          sub_d[k]   = sp_sr_d[k][55:0];
          sp_ok_d[k] = (sp_ecc_d[k] == sp_sr_d[k][63:56]);
        end
      end
      if (idx_q == 5'd31) begin
        valid_d   = 1'b1;
        header_d  = hdr_sr_d[23:0];
        hdr_ok_d  = (hdr_ecc_d == hdr_sr_d[31:24]);
        pkt_cnt_d = pkt_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      idx_q     <= '0;
      pkt_cnt_q <= '0;
      more_q    <= 1'b0;
      hdr_sr_q  <= '0;
      hdr_ecc_q <= '0;
      sp_sr_q   <= '0;
      sp_ecc_q  <= '0;
      header_q  <= '0;
      sub_q     <= '0;
      hdr_ok_q  <= 1'b0;
      sp_ok_q   <= '0;
      active_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      idx_q     <= idx_d;
      pkt_cnt_q <= pkt_cnt_d;
      more_q    <= more_d;
      hdr_sr_q  <= hdr_sr_d;
      hdr_ecc_q <= hdr_ecc_d;
      sp_sr_q   <= sp_sr_d;
      sp_ecc_q  <= sp_ecc_d;
      header_q  <= header_d;
      sub_q     <= sub_d;
      hdr_ok_q  <= hdr_ok_d;
      sp_ok_q   <= sp_ok_d;
      active_q  <= active_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign rx.dataIslandActive = active_q;
  assign rx.packetValid      = valid_q;
  assign rx.header           = header_q;
  assign rx.subpacket0       = sub_q[0];
  assign rx.subpacket1       = sub_q[1];
  assign rx.subpacket2       = sub_q[2];
  assign rx.subpacket3       = sub_q[3];
  assign rx.headerEccOk      = hdr_ok_q;
  assign rx.subpacketEccOk   = sp_ok_q;
  assign rx.hSyncOut         = hsync_q;
  assign rx.vSyncOut         = vsync_q;
  assign rx.islandError      = err_q;
endmodule

// File: tb/tb_data_island_packet_receiver.sv
// Bench for data_island_packet_receiver: a TX-side island builder feeds characters and queues
// the expected packets/errors/active spans; a negedge monitor pops and compares them.
module tb_data_island_packet_receiver;
  localparam logic [9:0] PRE_C = 10'b0010101011;
  localparam logic [9:0] GB_C  = 10'b0100110011;
  localparam logic [9:0] CTL0  = 10'b1101010100;

  typedef struct {
    bit          is_err;
    logic [23:0] hdr;
    logic [223:0] sp;
    logic        hok;
    logic [3:0]  spok;
    logic        hs;
    logic        vs;
    bit          b2b;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  data_island_packet_receiver_if bus();

  data_island_packet_receiver #(.MIN_PREAMBLE(8), .MAX_PACKETS(18)) dut (
    .pixelClock (clk),
    .resetN     (rstn),
    .rx         (bus)
  );

  logic [9:0] terc4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  logic [23:0]      pk_hdr [20];
  logic [3:0][55:0] pk_sp  [20];

  exp_t exp_q[$];
  int   run_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   run_cnt = 0;
  int   last_valid_cyc = 0;
  exp_t mon_e;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BCH parity byte over the first n bits, bit 0 first.
  function automatic logic [7:0] ecc_of(input logic [55:0] d, input int n);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < n; i++) e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
    return e;
  endfunction

  task automatic send(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    @(posedge clk);
    #1;
    bus.channel0 = c0;
    bus.channel1 = c1;
    bus.channel2 = c2;
  endtask

  task automatic idle(input int n);
    repeat (n) send(CTL0, CTL0, CTL0);
  endtask

  task automatic check_zero_outputs();
    check("reset_ctrl", 256'({bus.dataIslandActive, bus.packetValid, bus.islandError, bus.hSyncOut,
                              bus.vSyncOut, bus.headerEccOk, bus.subpacketEccOk, bus.header}), 256'(0));
    check("reset_data", 256'({bus.subpacket3, bus.subpacket2, bus.subpacket1, bus.subpacket0}), 256'(0));
  endtask

  // err_mode: 0 none, 1 ch1=3FF at (err_pkt,err_char), 2 error expected at that char with valid data,
  //           3 second trailing GB missing, 4 reset asserted in place of that char.
  task automatic send_island(input int npre, input int npk, input logic hs, input logic vs,
                             input int err_mode, input int err_pkt, input int err_char, input int flip);
    logic [31:0]      h32;
    logic [3:0][63:0] s64;
    logic [3:0]       n1, n2;
    logic [9:0]       c0, c1, c2;
    bit               live, stop;
    int               run;
    exp_t             e;
    live = (npre >= 8);
    stop = 1'b0;
    repeat (npre) send(CTL0, PRE_C, PRE_C);
    repeat (2) send(terc4_tab[{2'b11, vs, hs}], GB_C, GB_C);
    run = 2;
    for (int p = 0; p < npk && !stop; p++) begin
      h32 = {ecc_of(56'(pk_hdr[p]), 24), pk_hdr[p]};
      for (int k = 0; k < 4; k++) s64[k] = {ecc_of(pk_sp[p][k], 56), pk_sp[p][k]};
      if (flip >= 0 && p == 0) s64[2][flip] = ~s64[2][flip];
      for (int i = 0; i < 32; i++) begin
        for (int k = 0; k < 4; k++) begin
          n1[k] = s64[k][2*i];
          n2[k] = s64[k][2*i+1];
        end
        c0 = terc4_tab[{i != 0, h32[i], vs, hs}];
        c1 = terc4_tab[n1];
        c2 = terc4_tab[n2];
        if (p == err_pkt && i == err_char && err_mode inside {1, 2, 4}) begin
          stop = 1'b1;
          if (err_mode == 4) begin
            @(posedge clk);
            #1;
            rstn = 1'b0;
            #2;
            check_zero_outputs();
            idle(3);
            rstn = 1'b1;
            break;
          end
          if (err_mode == 1) c1 = 10'h3FF;
          if (live) begin
            e = '{default: '0};
            e.is_err = 1'b1;
            exp_q.push_back(e);
          end
          send(c0, c1, c2);
          break;
        end
        if (live && i == 31) begin
          e.is_err = 1'b0;
          e.hdr    = pk_hdr[p];
          e.sp     = {s64[3][55:0], s64[2][55:0], s64[1][55:0], s64[0][55:0]};
          e.hok    = 1'b1;
          e.spok   = (flip >= 0 && p == 0) ? 4'b1011 : 4'hF;
          e.hs     = hs;
          e.vs     = vs;
          e.b2b    = (p > 0);
          exp_q.push_back(e);
        end
        send(c0, c1, c2);
        run++;
      end
    end
    if (!stop) begin
      send(terc4_tab[{2'b11, vs, hs}], GB_C, GB_C);
      run++;
      if (err_mode == 3) begin
        if (live) begin
          e = '{default: '0};
          e.is_err = 1'b1;
          exp_q.push_back(e);
        end
      end else begin
        send(terc4_tab[{2'b11, vs, hs}], GB_C, GB_C);
        run++;
      end
    end
    if (live && err_mode != 4) run_q.push_back(run);
  endtask

  task automatic randomize_packets(input int n);
    for (int p = 0; p < n; p++) begin
      pk_hdr[p] = 24'($urandom);
      for (int k = 0; k < 4; k++) pk_sp[p][k] = {24'($urandom), 32'($urandom)};
    end
  endtask

  // Monitor: active-span lengths and packet/error events against the queues.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      run_cnt = 0;
    end else begin
      if (bus.dataIslandActive) begin
        run_cnt++;
      end else if (run_cnt != 0) begin
        if (run_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL active_run: unexpected span of %0d cycles", run_cnt);
        end else begin
          check("active_run", 256'(run_cnt), 256'(run_q.pop_front()));
        end
        run_cnt = 0;
      end
      if (bus.packetValid || bus.islandError) begin
        check("valid_err_exclusive", 256'(bus.packetValid & bus.islandError), 256'(0));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL event: unexpected valid=%0b err=%0b at cycle %0d",
                   bus.packetValid, bus.islandError, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_kind", 256'(bus.islandError), 256'(mon_e.is_err));
          if (!mon_e.is_err && bus.packetValid) begin
            check("header", 256'(bus.header), 256'(mon_e.hdr));
            check("subpackets", 256'({bus.subpacket3, bus.subpacket2, bus.subpacket1, bus.subpacket0}),
                  256'(mon_e.sp));
            check("header_ecc_ok", 256'(bus.headerEccOk), 256'(mon_e.hok));
            check("subpacket_ecc_ok", 256'(bus.subpacketEccOk), 256'(mon_e.spok));
            check("sync", 256'({bus.hSyncOut, bus.vSyncOut}), 256'({mon_e.hs, mon_e.vs}));
            if (mon_e.b2b) check("b2b_gap", 256'(cyc - last_valid_cyc), 256'(32));
          end
        end
        if (bus.packetValid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.channel0 = CTL0;
    bus.channel1 = CTL0;
    bus.channel2 = CTL0;
    #12;
    check_zero_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3);

    // AVI infoframe, clean.
    randomize_packets(2);
    pk_hdr[0] = 24'h0D0282;
    send_island(8, 1, 1'b1, 1'b0, 0, -1, -1, -1);
    idle(4);
    // Same with subpacket2 bit 5 flipped.
    send_island(8, 1, 1'b0, 1'b1, 0, -1, -1, 5);
    idle(4);
    // Too short a preamble: ignored entirely.
    send_island(7, 1, 1'b1, 1'b1, 0, -1, -1, -1);
    idle(4);
    // Two packets in one island.
    pk_hdr[1] = 24'h0A0184;
    send_island(8, 2, 1'b1, 1'b0, 0, -1, -1, -1);
    idle(4);
    // Invalid code on ch1 at char 10, then a good island.
    send_island(9, 1, 1'b0, 1'b0, 1, 0, 10, -1);
    idle(4);
    send_island(8, 1, 1'b1, 1'b1, 0, -1, -1, -1);
    idle(4);
    // Reset in the middle of a packet, then a good island.
    randomize_packets(1);
    send_island(8, 1, 1'b1, 1'b0, 4, 0, 20, -1);
    idle(2);
    send_island(8, 1, 1'b0, 1'b1, 0, -1, -1, -1);
    idle(4);
    // Packet count overflow: 18 good packets, the 19th start char is an error.
    randomize_packets(19);
    send_island(10, 19, 1'b1, 1'b0, 2, 18, 0, -1);
    idle(4);
    // Missing second trailing guard band.
    randomize_packets(1);
    send_island(8, 1, 1'b0, 1'b0, 3, -1, -1, -1);
    idle(4);
    // Random islands, including back-to-back with no gap and saturating preamble counts.
    for (int n = 0; n < 20; n++) begin
      int npk;
      npk = int'($urandom_range(1, 3));
      randomize_packets(npk);
      send_island(int'($urandom_range(8, 20)), npk, 1'($urandom), 1'($urandom), 0, -1, -1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);
    check("pending_events", 256'(exp_q.size()), 256'(0));
    check("pending_runs", 256'(run_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
